// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WORDS*32-bit adder/subtractor that streams one
// 32-bit slice per cycle through a single Kogge-Stone adder, carrying between
// slices through a register, behind valid/ready handshakes on both sides.

// koggstone32: 32-bit parallel-prefix (Kogge-Stone) adder with carry in/out.
module koggstone32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] p0;
  logic [31:0] gv;
  logic [31:0] pv;
  logic [31:0] cout;

  // Prefix tree: five levels of span-doubling generate/propagate merges.
  always_comb begin
    p0 = a ^ b;
    gv = a & b;
    pv = p0;
    for (int lvl = 0; lvl < 5; lvl++) begin
      gv = gv | (pv & (gv << (32'd1 << lvl)));
      pv = pv & ((pv << (32'd1 << lvl)) | ((32'd1 << (32'd1 << lvl)) - 32'd1));
    end
    // group (g, p) over bits [i:0] combined with the external carry-in
    cout = gv | (pv & {32{ci}});
    s    = p0 ^ {cout[30:0], ci};
    co   = cout[31];
  end

endmodule

// wide_add_seq: top-level sequencer around one koggstone32.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [WORDS*32-1:0] a,
  input  logic [WORDS*32-1:0] b,
  input  logic                ci,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDS*32-1:0] s,
  output logic                co,
  output logic                ovf
);

  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [KW-1:0]          k;
  logic                   c;
  logic                   op_q;
  logic [WORDS-1:0][31:0] a_q;
  logic [WORDS-1:0][31:0] b_q;
  logic [WORDS-1:0][31:0] s_q;
  logic                   co_q;
  logic                   ovf_q;

  logic [31:0] sl_a;
  logic [31:0] sl_b;
  logic [31:0] sl_sum;
  logic        sl_co;

  // Slice k of the latched operands; subtract is a + ~b + 1 with the +1
  // entering through the carry register loaded at accept.
  assign sl_a = a_q[k];
  assign sl_b = b_q[k] ^ {32{op_q}};

  koggstone32 u_add (
    .a  (sl_a),
    .b  (sl_b),
    .ci (c),
    .s  (sl_sum),
    .co (sl_co)
  );

  assign s   = s_q;
  assign co  = co_q;
  assign ovf = ovf_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; both ready/valid come from state only
  // (in_ready is additionally masked while reset is held).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture on accept, one slice per RUN cycle, flags on
  // the last slice. Results are left untouched in DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      c     <= 1'b0;
      op_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            c    <= op ? 1'b1 : ci;
            k    <= '0;
          end
        end
        RUN: begin
          s_q[k] <= sl_sum;
          c      <= sl_co;
          if (k == K_LAST) begin
            co_q  <= sl_co;
            ovf_q <= (sl_a[31] == sl_b[31]) & (sl_sum[31] != sl_a[31]);
          end else begin
            k <= k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq: directed corner cases plus randomized
// back-to-back traffic on a WORDS=4 and a WORDS=2 instance, with results
// checked by a scoreboard against a plain-arithmetic reference model.
module tb_wide_add_seq;

  typedef struct packed {
    logic [127:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  // WORDS=4 instance signals
  logic         in_valid4, in_ready4, op4, ci4, out_valid4, out_ready4, co4, ovf4;
  logic [127:0] a4, b4, s4;
  // WORDS=2 instance signals
  logic         in_valid2, in_ready2, op2, ci2, out_valid2, out_ready2, co2, ovf2;
  logic [63:0]  a2, b2, s2;

  exp_t exp4_q[$];
  exp_t exp2_q[$];
  logic b2b4, b2b2;
  int   last4, last2;

  wide_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op4), .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4),
    .out_ready(out_ready4), .s(s4), .co(co4), .ovf(ovf4)
  );

  wide_add_seq #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op2), .a(a2), .b(b2), .ci(ci2), .out_valid(out_valid2),
    .out_ready(out_ready2), .s(s2), .co(co2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: w-bit add/subtract from ordinary integer arithmetic.
  function automatic exp_t model(input int w, input logic o, input logic [127:0] x_in,
                                 input logic [127:0] y_in, input logic c);
    exp_t r;
    logic [128:0] full;
    logic [127:0] mask, x, y;
    logic sa, sb, ss;
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    x = x_in & mask;
    y = y_in & mask;
    if (!o) begin
      full = {1'b0, x} + {1'b0, y} + {128'd0, c};
      r.s  = full[127:0] & mask;
      r.co = full[w];
    end else begin
      r.s  = (x - y) & mask;
      r.co = (x >= y);
    end
    sa = x[w-1];
    sb = y[w-1];
    ss = r.s[w-1];
    r.ovf = o ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    case ($urandom_range(0, 5))
      0: v = {128{1'b1}};
      1: v = 128'd0;
      2: v = {1'b0, {127{1'b1}}};
      3: v = {1'b1, 127'd0};
      default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Accept monitors: push the model result for every operand set taken.
  always @(negedge clk) begin
    if (!rst && in_valid4 === 1'b1 && in_ready4 === 1'b1) begin
      exp4_q.push_back(model(128, op4, a4, b4, ci4));
      if (b2b4 && last4 >= 0) begin
        checks++;
        if (cyc - last4 != 6) begin
          errors++;
          $display("FAIL spacing4: got %0d cycles expected 6", cyc - last4);
        end
      end
      last4 = cyc;
    end
    if (!rst && in_valid2 === 1'b1 && in_ready2 === 1'b1) begin
      exp2_q.push_back(model(64, op2, {64'd0, a2}, {64'd0, b2}, ci2));
      if (b2b2 && last2 >= 0) begin
        checks++;
        if (cyc - last2 != 4) begin
          errors++;
          $display("FAIL spacing2: got %0d cycles expected 4", cyc - last2);
        end
      end
      last2 = cyc;
    end
  end

  // Result monitors: pop and compare on every output transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL result4: unexpected result s=%h", s4);
      end else begin
        e = exp4_q.pop_front();
        if (s4 !== e.s || co4 !== e.co || ovf4 !== e.ovf) begin
          errors++;
          $display("FAIL result4: got s=%h co=%b ovf=%b expected s=%h co=%b ovf=%b",
                   s4, co4, ovf4, e.s, e.co, e.ovf);
        end
      end
    end
    if (!rst && out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL result2: unexpected result s=%h", s2);
      end else begin
        e = exp2_q.pop_front();
        if (s2 !== e.s[63:0] || co2 !== e.co || ovf2 !== e.ovf) begin
          errors++;
          $display("FAIL result2: got s=%h co=%b ovf=%b expected s=%h co=%b ovf=%b",
                   s2, co2, ovf2, e.s[63:0], e.co, e.ovf);
        end
      end
    end
  end

  // Present operands and hold in_valid until the accept edge; returns #1
  // after that edge.
  task automatic send4(input logic o, input logic [127:0] x, input logic [127:0] y,
                       input logic c);
    int n;
    n = 0;
    op4 = o; a4 = x; b4 = y; ci4 = c; in_valid4 = 1'b1;
    while (in_ready4 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready4 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept4: in_ready never rose");
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then step past the transfer edge.
  task automatic wait_out4();
    int n;
    n = 0;
    while (out_valid4 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid4 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout4: out_valid never rose");
    end
    @(posedge clk); #1;
  endtask

  initial begin : main
    exp_t e;
    logic [127:0] t;
    cyc = 0; checks = 0; errors = 0;
    b2b4 = 1'b0; b2b2 = 1'b0; last4 = -1; last2 = -1;
    rst = 1'b1;
    in_valid4 = 1'b0; op4 = 1'b0; a4 = 128'd0; b4 = 128'd0; ci4 = 1'b0; out_ready4 = 1'b1;
    in_valid2 = 1'b0; op2 = 1'b0; a2 = 64'd0; b2 = 64'd0; ci2 = 1'b0; out_ready2 = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready4, 0);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_s", s4, 0);
    chk("rst_co", co4, 0);
    chk("rst_ovf", ovf4, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready4, 1);

    // full ripple with latency check
    send4(1'b0, {128{1'b1}}, 128'd1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("latency_low", out_valid4, 0);
    end
    @(posedge clk); #1;
    chk("latency_high", out_valid4, 1);
    @(posedge clk); #1;

    // borrow, ci ignored on subtract, signed overflow both ways
    send4(1'b1, 128'd0, 128'd1, 1'b0);             wait_out4();
    send4(1'b1, 128'd5, 128'd3, 1'b1);             wait_out4();
    send4(1'b0, {1'b0, {127{1'b1}}}, 128'd1, 1'b0); wait_out4();
    send4(1'b1, {1'b1, 127'd0}, 128'd1, 1'b0);      wait_out4();

    // random single operations
    repeat (12) begin
      send4(1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'($urandom_range(0, 1)));
      wait_out4();
    end

    // backpressure: result held, inputs ignored, in_ready low
    out_ready4 = 1'b0;
    e = model(128, 1'b0, {128{1'b1}}, 128'd7, 1'b1);
    send4(1'b0, {128{1'b1}}, 128'd7, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      a4 = rnd128(); b4 = rnd128(); op4 = 1'($urandom_range(0, 1)); in_valid4 = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid4, 1);
      chk("bp_in_ready", in_ready4, 0);
      chk("bp_s", s4, e.s);
      chk("bp_co", co4, e.co);
      chk("bp_ovf", ovf4, e.ovf);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready4, 1);
    chk("bp_release_out_valid", out_valid4, 0);

    // reset two cycles after accept aborts the operation
    send4(1'b0, rnd128(), rnd128(), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    void'(exp4_q.pop_back());
    chk("midrst_out_valid", out_valid4, 0);
    chk("midrst_s", s4, 0);
    chk("midrst_co", co4, 0);
    chk("midrst_in_ready", in_ready4, 1);
    send4(1'b0, 128'd10, 128'd20, 1'b0);
    wait_out4();
    chk("fresh_s", s4, 128'd30);

    // back-to-back, WORDS=4
    b2b4 = 1'b1; last4 = -1; in_valid4 = 1'b1;
    repeat (72) begin
      op4 = 1'($urandom_range(0, 1)); ci4 = 1'($urandom_range(0, 1));
      a4 = rnd128(); b4 = rnd128();
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0; b2b4 = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // back-to-back, WORDS=2
    b2b2 = 1'b1; last2 = -1; in_valid2 = 1'b1;
    repeat (60) begin
      op2 = 1'($urandom_range(0, 1)); ci2 = 1'($urandom_range(0, 1));
      t = rnd128(); a2 = t[63:0];
      t = rnd128(); b2 = t[127:64];
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0; b2b2 = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    chk("drained4", 128'(exp4_q.size()), 0);
    chk("drained2", 128'(exp2_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
